axil_arb_2to1: RTL and testbench

Two-master AXI-Lite arbiter that shares one downstream `m_axil` port between a UART-bridged master and a second on-chip master (e.g. a CPU or DMA). Write and read paths are arbitrated independently. Each path uses round-robin priority and allows one outstanding transaction per path. The block sits between `axil_uart_master` (and its peer master) and the AXI-Lite interconnect/slave.

---
 rtl/axil_pkg.sv | 24 ++
 rtl/axil_if.sv | 38 +++
 rtl/axil_rr_grant.sv | 34 +++
 rtl/axil_arb_2to1.sv | 259 +++++++++++++++++++++++++
 tb/tb_axil_arb_2to1.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// Shared AXI-Lite widths, arbiter FSM state types and response codes.
// Imported by the arbiter, its grant register and the bus interface.
package axil_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    function automatic logic [1:0] rr_pick(
        input logic [1:0] req,
        input logic       prio
    );
        if (req == 2'b11) begin
            return prio ? 2'b10 : 2'b01;
        end
        return req;
    endfunction

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bundle; s_axil faces an upstream master, m_axil drives a slave.
// No clock inside: the arbiter takes aclk/aresetn as plain ports.
interface axil_if;
    import axil_pkg::*;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport s_axil (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

    modport m_axil (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_rr_grant.sv
// Two-requester round-robin grant register: latches a one-hot grant while
// idle and hands priority to the other requester when `done` retires it.
module axil_rr_grant
    import axil_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       done,
    output logic [1:0] grant,
    output logic       busy
);

    logic [1:0] grant_q;
    logic       prio_q;

    assign grant = grant_q;
    assign busy  = |grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= 2'b00;
            prio_q  <= 1'b0;
        end else if (busy) begin
            if (done) begin
                grant_q <= 2'b00;
                prio_q  <= grant_q[0];
            end
        end else if (|req) begin
            grant_q <= rr_pick(req, prio_q);
        end
    end

endmodule

// File: rtl/axil_arb_2to1.sv
// Two-master AXI-Lite arbiter with independent round-robin write/read paths.
// Define AXIL_ARB_TIMEOUT_EN to add a per-path SLVERR response timeout.
module axil_arb_2to1
    import axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic   aclk,
    input  logic   aresetn,
    axil_if.s_axil s0_axil,
    axil_if.s_axil s1_axil,
    axil_if.m_axil m_axil
);

    if (TIMEOUT_CYCLES < 4) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 4");
    end

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;

    logic [1:0] w_req, wg, r_req, rg;
    logic       w_busy, w_done, r_busy, r_done;
    logic       aw_done_q, w_done_q, aw_hs, w_hs;
    logic       w_to, r_to;

    logic       g_awvalid, g_wvalid, g_bready;
    logic       g_arvalid, g_rready;
    logic       awready_g, wready_g, bvalid_g;
    logic [1:0] bresp_g;
    logic       arready_g, rvalid_g;
    logic [1:0] rresp_g;
    logic [DATA_WIDTH-1:0] rdata_g;

    assign w_req = w_busy ? 2'b00 : {s1_axil.awvalid, s0_axil.awvalid};
    assign r_req = r_busy ? 2'b00 : {s1_axil.arvalid, s0_axil.arvalid};

    axil_rr_grant u_w_rr (
        .clk   (aclk),
        .rst_n (aresetn),
        .req   (w_req),
        .done  (w_done),
        .grant (wg),
        .busy  (w_busy)
    );

    axil_rr_grant u_r_rr (
        .clk   (aclk),
        .rst_n (aresetn),
        .req   (r_req),
        .done  (r_done),
        .grant (rg),
        .busy  (r_busy)
    );

    always_comb begin
        g_awvalid     = 1'b0;
        g_wvalid      = 1'b0;
        g_bready      = 1'b0;
        m_axil.awaddr = '0;
        m_axil.wdata  = '0;
        m_axil.wstrb  = '0;
        unique case (1'b1)
            wg[0]: begin
                g_awvalid     = s0_axil.awvalid;
                g_wvalid      = s0_axil.wvalid;
                g_bready      = s0_axil.bready;
                m_axil.awaddr = s0_axil.awaddr;
                m_axil.wdata  = s0_axil.wdata;
                m_axil.wstrb  = s0_axil.wstrb;
            end
            wg[1]: begin
                g_awvalid     = s1_axil.awvalid;
                g_wvalid      = s1_axil.wvalid;
                g_bready      = s1_axil.bready;
                m_axil.awaddr = s1_axil.awaddr;
                m_axil.wdata  = s1_axil.wdata;
                m_axil.wstrb  = s1_axil.wstrb;
            end
            default: ;
        endcase
    end

    always_comb begin
        g_arvalid     = 1'b0;
        g_rready      = 1'b0;
        m_axil.araddr = '0;
        unique case (1'b1)
            rg[0]: begin
                g_arvalid     = s0_axil.arvalid;
                g_rready      = s0_axil.rready;
                m_axil.araddr = s0_axil.araddr;
            end
            rg[1]: begin
                g_arvalid     = s1_axil.arvalid;
                g_rready      = s1_axil.rready;
                m_axil.araddr = s1_axil.araddr;
            end
            default: ;
        endcase
    end

    // AW and W retire independently; W_RESP needs both, in either order.
    always_comb begin
        w_state_d      = w_state_q;
        m_axil.awvalid = 1'b0;
        m_axil.wvalid  = 1'b0;
        m_axil.bready  = 1'b0;
        aw_hs          = 1'b0;
        w_hs           = 1'b0;
        awready_g      = 1'b0;
        wready_g       = 1'b0;
        bvalid_g       = 1'b0;
        bresp_g        = 2'b00;
        w_done         = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
`ifdef AXIL_ARB_TIMEOUT_EN
                m_axil.bready = aresetn;
`endif
                if (|w_req) w_state_d = W_ADDR;
            end
            W_ADDR: begin
                m_axil.awvalid = g_awvalid & ~aw_done_q;
                m_axil.wvalid  = g_wvalid & ~w_done_q;
                awready_g      = m_axil.awready & ~aw_done_q;
                wready_g       = m_axil.wready & ~w_done_q;
                aw_hs          = m_axil.awvalid & m_axil.awready;
                w_hs           = m_axil.wvalid & m_axil.wready;
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (w_to) begin
                    bvalid_g = 1'b1;
                    bresp_g  = RESP_SLVERR;
                    w_done   = g_bready;
                end else begin
                    m_axil.bready = g_bready;
                    bvalid_g      = m_axil.bvalid;
                    bresp_g       = m_axil.bresp;
                    w_done        = m_axil.bvalid & g_bready;
                end
                if (w_done) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d      = r_state_q;
        m_axil.arvalid = 1'b0;
        m_axil.rready  = 1'b0;
        arready_g      = 1'b0;
        rvalid_g       = 1'b0;
        rresp_g        = 2'b00;
        rdata_g        = '0;
        r_done         = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
`ifdef AXIL_ARB_TIMEOUT_EN
                m_axil.rready = aresetn;
`endif
                if (|r_req) r_state_d = R_ADDR;
            end
            R_ADDR: begin
                m_axil.arvalid = g_arvalid;
                arready_g      = m_axil.arready;
                if (g_arvalid & m_axil.arready) r_state_d = R_DATA;
            end
            R_DATA: begin
                if (r_to) begin
                    rvalid_g = 1'b1;
                    rresp_g  = RESP_SLVERR;
                    r_done   = g_rready;
                end else begin
                    m_axil.rready = g_rready;
                    rvalid_g      = m_axil.rvalid;
                    rresp_g       = m_axil.rresp;
                    rdata_g       = m_axil.rdata;
                    r_done        = m_axil.rvalid & g_rready;
                end
                if (r_done) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            if (w_state_q == W_ADDR && w_state_d == W_ADDR) begin
                aw_done_q <= aw_done_q | aw_hs;
                w_done_q  <= w_done_q | w_hs;
            end else begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
        end
    end

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] w_cnt_q, r_cnt_q;

    assign w_to = (w_cnt_q == TO_LAST);
    assign r_to = (r_cnt_q == TO_LAST);

    // Counters freeze once a real response shows up so it is never replaced.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_cnt_q <= '0;
            r_cnt_q <= '0;
        end else begin
            if (w_state_q != W_RESP) begin
                w_cnt_q <= '0;
            end else if (!w_to && !m_axil.bvalid) begin
                w_cnt_q <= w_cnt_q + 1'b1;
            end
            if (r_state_q != R_DATA) begin
                r_cnt_q <= '0;
            end else if (!r_to && !m_axil.rvalid) begin
                r_cnt_q <= r_cnt_q + 1'b1;
            end
        end
    end
`else
    assign w_to = 1'b0;
    assign r_to = 1'b0;
`endif

    assign s0_axil.awready = wg[0] & awready_g;
    assign s0_axil.wready  = wg[0] & wready_g;
    assign s0_axil.bvalid  = wg[0] & bvalid_g;
    assign s0_axil.bresp   = wg[0] ? bresp_g : 2'b00;
    assign s0_axil.arready = rg[0] & arready_g;
    assign s0_axil.rvalid  = rg[0] & rvalid_g;
    assign s0_axil.rresp   = rg[0] ? rresp_g : 2'b00;
    assign s0_axil.rdata   = rg[0] ? rdata_g : '0;

    assign s1_axil.awready = wg[1] & awready_g;
    assign s1_axil.wready  = wg[1] & wready_g;
    assign s1_axil.bvalid  = wg[1] & bvalid_g;
    assign s1_axil.bresp   = wg[1] ? bresp_g : 2'b00;
    assign s1_axil.arready = rg[1] & arready_g;
    assign s1_axil.rvalid  = rg[1] & rvalid_g;
    assign s1_axil.rresp   = rg[1] ? rresp_g : 2'b00;
    assign s1_axil.rdata   = rg[1] ? rdata_g : '0;

endmodule

// File: tb/tb_axil_arb_2to1.sv
// Directed bench for axil_arb_2to1: arbitration order, channel routing,
// AW/W ordering, reset abort and (with AXIL_ARB_TIMEOUT_EN) the SLVERR timeout.
module tb_axil_arb_2to1;
    import axil_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int   n_asrt = 0;
    int   n_fail = 0;

    always #5 aclk = ~aclk;

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    axil_if s0_if ();
    axil_if s1_if ();
    axil_if m_if ();

    axil_arb_2to1 #(.TIMEOUT_CYCLES(TO)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s0_axil (s0_if),
        .s1_axil (s1_if),
        .m_axil  (m_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr();
        s0_if.awaddr = '0; s0_if.awvalid = 0; s0_if.wdata = '0;
        s0_if.wstrb = '0;  s0_if.wvalid = 0;  s0_if.bready = 0;
        s0_if.araddr = '0; s0_if.arvalid = 0; s0_if.rready = 0;
        s1_if.awaddr = '0; s1_if.awvalid = 0; s1_if.wdata = '0;
        s1_if.wstrb = '0;  s1_if.wvalid = 0;  s1_if.bready = 0;
        s1_if.araddr = '0; s1_if.arvalid = 0; s1_if.rready = 0;
        m_if.awready = 0;  m_if.wready = 0;   m_if.bresp = 2'b00;
        m_if.bvalid = 0;   m_if.arready = 0;  m_if.rdata = '0;
        m_if.rresp = 2'b00; m_if.rvalid = 0;
    endtask

    task automatic s0_wr(input logic [31:0] a, input logic [31:0] d);
        s0_if.awaddr = a; s0_if.awvalid = 1; s0_if.wdata = d;
        s0_if.wstrb = 4'hf; s0_if.wvalid = 1; s0_if.bready = 1;
    endtask

    task automatic s1_wr(input logic [31:0] a, input logic [31:0] d);
        s1_if.awaddr = a; s1_if.awvalid = 1; s1_if.wdata = d;
        s1_if.wstrb = 4'hf; s1_if.wvalid = 1; s1_if.bready = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        s0_if.awvalid = 1;
        s1_if.arvalid = 1;
        m_if.bvalid = 1;
        #2;
        chk("rst_m_awvalid", 32'(m_if.awvalid), 0);
        chk("rst_m_arvalid", 32'(m_if.arvalid), 0);
        chk("rst_s0_awready", 32'(s0_if.awready), 0);
        chk("rst_s0_bvalid", 32'(s0_if.bvalid), 0);
        chk("rst_m_bready", 32'(m_if.bready), 0);
        clr();
        cyc();
        cyc();
        aresetn = 1;

        // single s0 write, slave always ready
        cyc();
        s0_wr(32'h10, 32'hA5A5A5A5);
        m_if.awready = 1; m_if.wready = 1; m_if.arready = 1;
        settle();
        chk("t1_idle_awvalid", 32'(m_if.awvalid), 0);
        cyc(); settle();
        chk("t1_awvalid", 32'(m_if.awvalid), 1);
        chk("t1_awaddr", m_if.awaddr, 32'h10);
        chk("t1_wdata", m_if.wdata, 32'hA5A5A5A5);
        chk("t1_s0_awready", 32'(s0_if.awready), 1);
        chk("t1_s1_awready", 32'(s1_if.awready), 0);
        chk("t1_s1_wready", 32'(s1_if.wready), 0);
        cyc();
        s0_if.awvalid = 0; s0_if.wvalid = 0;
        m_if.bvalid = 1; m_if.bresp = 2'b00;
        settle();
        chk("t1_s0_bvalid", 32'(s0_if.bvalid), 1);
        chk("t1_s0_bresp", 32'(s0_if.bresp), 0);
        chk("t1_s1_bvalid", 32'(s1_if.bvalid), 0);
        chk("t1_m_bready", 32'(m_if.bready), 1);
        cyc();
        m_if.bvalid = 0;
        settle();
        chk("t1_done_bvalid", 32'(s0_if.bvalid), 0);
        aresetn = 0;
        #1;
        aresetn = 1;

        // simultaneous writes after reset: s0 first, then s1
        cyc();
        s0_wr(32'h10, 32'h11111111);
        s1_wr(32'h20, 32'h22222222);
        settle();
        cyc(); settle();
        chk("t2a_awaddr", m_if.awaddr, 32'h10);
        chk("t2a_s0_awready", 32'(s0_if.awready), 1);
        chk("t2a_s1_awready", 32'(s1_if.awready), 0);
        cyc();
        s0_if.awvalid = 0; s0_if.wvalid = 0;
        m_if.bvalid = 1;
        settle();
        chk("t2a_s0_bvalid", 32'(s0_if.bvalid), 1);
        chk("t2a_s1_bvalid", 32'(s1_if.bvalid), 0);
        cyc();
        m_if.bvalid = 0;
        settle();
        chk("t2_gap_awvalid", 32'(m_if.awvalid), 0);
        cyc(); settle();
        chk("t2b_awaddr", m_if.awaddr, 32'h20);
        chk("t2b_wdata", m_if.wdata, 32'h22222222);
        chk("t2b_s1_awready", 32'(s1_if.awready), 1);
        chk("t2b_s0_awready", 32'(s0_if.awready), 0);
        cyc();
        s1_if.awvalid = 0; s1_if.wvalid = 0;
        m_if.bvalid = 1;
        settle();
        chk("t2b_s1_bvalid", 32'(s1_if.bvalid), 1);
        chk("t2b_s0_bvalid", 32'(s0_if.bvalid), 0);

        // simultaneous reads: read priority still at s0
        cyc();
        m_if.bvalid = 0;
        s0_if.arvalid = 1; s0_if.araddr = 32'h100; s0_if.rready = 1;
        s1_if.arvalid = 1; s1_if.araddr = 32'h200; s1_if.rready = 1;
        settle();
        chk("t2r_idle_arvalid", 32'(m_if.arvalid), 0);
        cyc(); settle();
        chk("t2r_araddr0", m_if.araddr, 32'h100);
        chk("t2r_s0_arready", 32'(s0_if.arready), 1);
        chk("t2r_s1_arready", 32'(s1_if.arready), 0);
        cyc();
        s0_if.arvalid = 0;
        m_if.rvalid = 1; m_if.rdata = 32'hDEAD0001;
        settle();
        chk("t2r_s0_rvalid", 32'(s0_if.rvalid), 1);
        chk("t2r_s0_rdata", s0_if.rdata, 32'hDEAD0001);
        chk("t2r_s1_rvalid", 32'(s1_if.rvalid), 0);
        chk("t2r_s1_rdata", s1_if.rdata, 0);
        cyc();
        m_if.rvalid = 0;
        settle();
        chk("t2r_gap_arvalid", 32'(m_if.arvalid), 0);
        cyc(); settle();
        chk("t2r_araddr1", m_if.araddr, 32'h200);
        chk("t2r_s1_arready", 32'(s1_if.arready), 1);
        cyc();
        s1_if.arvalid = 0;
        m_if.rvalid = 1; m_if.rdata = 32'hDEAD0002;
        settle();
        chk("t2r_s1_rdata", s1_if.rdata, 32'hDEAD0002);
        chk("t2r_s0_rvalid_off", 32'(s0_if.rvalid), 0);

        // s1 read concurrent with s0 write
        cyc();
        m_if.rvalid = 0;
        s0_wr(32'h40, 32'h40404040);
        s1_if.arvalid = 1; s1_if.araddr = 32'h30;
        settle();
        cyc(); settle();
        chk("t3_awaddr", m_if.awaddr, 32'h40);
        chk("t3_araddr", m_if.araddr, 32'h30);
        chk("t3_s0_awready", 32'(s0_if.awready), 1);
        chk("t3_s1_arready", 32'(s1_if.arready), 1);
        chk("t3_s0_arready", 32'(s0_if.arready), 0);
        chk("t3_s1_awready", 32'(s1_if.awready), 0);
        cyc();
        s0_if.awvalid = 0; s0_if.wvalid = 0; s1_if.arvalid = 0;
        m_if.bvalid = 1; m_if.bresp = 2'b01;
        m_if.rvalid = 1; m_if.rdata = 32'h30303030;
        settle();
        chk("t3_s0_bvalid", 32'(s0_if.bvalid), 1);
        chk("t3_s0_bresp", 32'(s0_if.bresp), 1);
        chk("t3_s1_bvalid", 32'(s1_if.bvalid), 0);
        chk("t3_s1_rvalid", 32'(s1_if.rvalid), 1);
        chk("t3_s1_rdata", s1_if.rdata, 32'h30303030);
        chk("t3_s0_rvalid", 32'(s0_if.rvalid), 0);
        chk("t3_s0_rdata", s0_if.rdata, 0);

        // simultaneous writes with write priority at s1
        cyc();
        m_if.bvalid = 0; m_if.rvalid = 0; m_if.bresp = 2'b00;
        s0_wr(32'h50, 32'h55555555);
        s1_wr(32'h60, 32'h66666666);
        settle();
        cyc(); settle();
        chk("t2c_awaddr", m_if.awaddr, 32'h60);
        chk("t2c_s1_awready", 32'(s1_if.awready), 1);
        chk("t2c_s0_awready", 32'(s0_if.awready), 0);
        cyc();
        s1_if.awvalid = 0; s1_if.wvalid = 0;
        s0_if.awvalid = 0; s0_if.wvalid = 0;
        m_if.bvalid = 1;
        settle();
        chk("t2c_s1_bvalid", 32'(s1_if.bvalid), 1);
        chk("t2c_s0_bvalid", 32'(s0_if.bvalid), 0);

        // W three cycles ahead of AW, slave takes W before AW
        cyc();
        m_if.bvalid = 0;
        s0_if.wvalid = 1; s0_if.wdata = 32'h77; s0_if.wstrb = 4'hf;
        s0_if.bready = 1;
        settle();
        chk("t4_early_wready", 32'(s0_if.wready), 0);
        chk("t4_early_m_wvalid", 32'(m_if.wvalid), 0);
        cyc();
        cyc();
        cyc();
        s0_if.awvalid = 1; s0_if.awaddr = 32'h70;
        settle();
        chk("t4_idle_awvalid", 32'(m_if.awvalid), 0);
        cyc();
        m_if.awready = 0;
        settle();
        chk("t4_both_valid", {30'd0, m_if.awvalid, m_if.wvalid}, 32'b11);
        chk("t4_s0_wready", 32'(s0_if.wready), 1);
        chk("t4_s0_awready", 32'(s0_if.awready), 0);
        cyc();
        s0_if.wvalid = 0;
        m_if.awready = 1;
        settle();
        chk("t4_w_retired", 32'(m_if.wvalid), 0);
        chk("t4_aw_pending", 32'(m_if.awvalid), 1);
        cyc();
        s0_if.awvalid = 0;
        m_if.bvalid = 1;
        settle();
        chk("t4_resp_bvalid", 32'(s0_if.bvalid), 1);
        chk("t4_resp_no_w", 32'(m_if.wvalid), 0);

        // AW and W together
        cyc();
        m_if.bvalid = 0;
        s1_wr(32'h80, 32'h88888888);
        settle();
        cyc(); settle();
        chk("t5_both_valid", {30'd0, m_if.awvalid, m_if.wvalid}, 32'b11);
        chk("t5_awaddr", m_if.awaddr, 32'h80);
        cyc();
        s1_if.awvalid = 0; s1_if.wvalid = 0;
        m_if.bvalid = 1;
        settle();
        chk("t5_resp_valids", {30'd0, m_if.awvalid, m_if.wvalid}, 32'b00);
        chk("t5_s1_bvalid", 32'(s1_if.bvalid), 1);

        // reset during W_RESP
        cyc();
        m_if.bvalid = 0;
        s0_wr(32'h90, 32'h99999999);
        settle();
        cyc();
        cyc();
        s0_if.awvalid = 0; s0_if.wvalid = 0;
        settle();
        chk("t6_wait_bvalid", 32'(s0_if.bvalid), 0);
        chk("t6_wait_bready", 32'(m_if.bready), 1);
        m_if.bvalid = 1;
        aresetn = 0;
        settle();
        chk("t6_rst_bready", 32'(m_if.bready), 0);
        chk("t6_rst_s0_bvalid", 32'(s0_if.bvalid), 0);
        chk("t6_rst_awvalid", 32'(m_if.awvalid), 0);
        cyc();
        aresetn = 1;
        m_if.bvalid = 0;
        s0_if.bready = 0;
        s1_wr(32'hA0, 32'hAAAAAAAA);
        settle();
        chk("t6_idle_awvalid", 32'(m_if.awvalid), 0);
        cyc(); settle();
        chk("t6_awaddr", m_if.awaddr, 32'hA0);
        chk("t6_s1_awready", 32'(s1_if.awready), 1);
        cyc();
        s1_if.awvalid = 0; s1_if.wvalid = 0;
        m_if.bvalid = 1;
        settle();
        chk("t6_s1_bvalid", 32'(s1_if.bvalid), 1);
        cyc();
        m_if.bvalid = 0;

`ifdef AXIL_ARB_TIMEOUT_EN
        // slave never answers the read
        s0_if.arvalid = 1; s0_if.araddr = 32'h100; s0_if.rready = 1;
        m_if.rdata = 32'hFFFFFFFF;
        settle();
        cyc(); settle();
        chk("to_s0_arready", 32'(s0_if.arready), 1);
        cyc();
        s0_if.arvalid = 0;
        repeat (6) cyc();
        settle();
        chk("to_early_rvalid", 32'(s0_if.rvalid), 0);
        cyc(); settle();
        chk("to_rvalid", 32'(s0_if.rvalid), 1);
        chk("to_rresp", 32'(s0_if.rresp), 32'(RESP_SLVERR));
        chk("to_rdata", s0_if.rdata, 0);
        cyc();
        m_if.rvalid = 1;
        settle();
        chk("to_stale_rready", 32'(m_if.rready), 1);
        chk("to_stale_rvalid", 32'(s0_if.rvalid), 0);
        cyc();
        m_if.rvalid = 0;
`endif

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
